mem_access_unit: RTL and testbench

Parametrised MEM-stage unit for the pipelined CPU: it owns the data memory and performs byte, halfword and word loads and stores, with sign or zero extension on loads. It sits between the EX/MEM and MEM/WB pipeline registers. It adds a configurable read latency with a stall handshake back to the pipeline, plus misaligned-access detection. The ALU result and destination register pass through unchanged for write-back.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the EX/MEM register and the MEM-stage unit.
// Latency: none, this is wiring only.
// Backpressure: stall is driven by the slave, and the master must hold its request stable while stall is high.
interface mem_access_unit_if;
  logic        req_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  reg_target_in;
  logic [31:0] alu_ans_out;
  logic [4:0]  reg_target_out;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misalign_exc;

  modport master (
    output req_valid, mem_rd, mem_wr, size, load_unsigned, addr, wdata, reg_target_in,
    input  alu_ans_out, reg_target_out, rdata, rdata_valid, stall, misalign_exc
  );

  modport slave (
    input  req_valid, mem_rd, mem_wr, size, load_unsigned, addr, wdata, reg_target_in,
    output alu_ans_out, reg_target_out, rdata, rdata_valid, stall, misalign_exc
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data memory: byte/half/word loads and stores, sign or zero extension, optional misalign trap (MEMU_ALIGN_TRAP_EN).
// Latency: stores take effect at the end of the request cycle; loads are valid RD_LAT cycles after acceptance (RD_LAT=0 means combinational).
// Backpressure: stall is high from the load request cycle through RD_LAT-1, and the pipeline holds its inputs during that time.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 2
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // The counter is loaded with RD_LAT-1 on accept and leaves WAIT as it reaches zero.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  // Data memory is not reset, so it keeps its contents across rst_n.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          misaligned, trap, req_ok, do_store, do_load;
  logic [3:0]    be;
  logic [31:0]   wword, rd_word, rd_ext, wmerge;
  logic          stall_c, valid_c;
  logic [31:0]   rdata_c;
  logic          unused_addr_hi;

  // Higher address bits are dropped so accesses wrap modulo 4*DEPTH_WORDS.
  assign idx            = bus.addr[AW+1:2];
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign misaligned = (bus.size == 2'b01) ? bus.addr[0] :
                      (bus.size[1]        ? |bus.addr[1:0] : 1'b0);

  // When the trap is off, misaligned halfword and word offsets are truncated.
  // When the trap is on, those requests never reach memory, so the same offset works for both builds.
  assign off = (bus.size == 2'b00) ? bus.addr[1:0] :
               (bus.size == 2'b01) ? {bus.addr[1], 1'b0} : 2'b00;

`ifdef MEMU_ALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  // Request inputs are sampled only in IDLE.
  // rst_n gates acceptance so a held request cannot raise stall during reset.
  assign req_ok   = rst_n && bus.req_valid && (state_q == S_IDLE) && (bus.mem_rd || bus.mem_wr);
  assign do_store = req_ok && !trap && bus.mem_wr;
  assign do_load  = req_ok && !trap && bus.mem_rd && !bus.mem_wr;

  assign bus.misalign_exc   = req_ok && trap;
  assign bus.alu_ans_out    = bus.addr;
  assign bus.reg_target_out = bus.reg_target_in;
  assign bus.stall          = stall_c;
  assign bus.rdata_valid    = valid_c;
  assign bus.rdata          = rdata_c;

  assign rd_word = mem_q[idx];

  // Select the load lane, then sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  assign rd_ext = load_ext(rd_word, off, bus.size, bus.load_unsigned);

  // Build the byte enables and the replicated store data, then merge them into the old word.
  always_comb begin
    be    = 4'hF;
    wword = bus.wdata;
    case (bus.size)
      2'b00: begin
        be    = 4'b0001 << off;
        wword = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
    wmerge = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wmerge[8*i +: 8] = wword[8*i +: 8];
    end
  end

  // Store write port: a single-cycle write, which never stalls.
  always_ff @(posedge clk) begin
    if (do_store) mem_q[idx] <= wmerge;
  end

  // FSM state, latency counter and held load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic plus stall, valid and rdata outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    valid_c = 1'b0;
    rdata_c = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (do_load) begin
          if (RD_LAT == 0) begin
            valid_c = 1'b1;
            rdata_c = rd_ext;
          end else begin
            // Capture the word now. No store can land while the pipeline is stalled.
            stall_c = 1'b1;
            rdata_d = rd_ext;
            if (RD_LAT == 1) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = S_DONE;
      end
      S_DONE: begin
        // The pipeline advances at the end of this cycle, so the request is consumed.
        valid_c = 1'b1;
        rdata_c = rdata_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with two instances: dut_a uses RD_LAT=2 and dut_b uses RD_LAT=0.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_mem_access_unit;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if a_if ();
  mem_access_unit_if b_if ();

  mem_access_unit #(.DEPTH_WORDS(1024), .RD_LAT(LAT)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  mem_access_unit #(.DEPTH_WORDS(1024), .RD_LAT(0))   dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic a_drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rt);
    a_if.req_valid     = 1'b1;
    a_if.mem_rd        = rd;
    a_if.mem_wr        = wr;
    a_if.size          = sz;
    a_if.load_unsigned = uns;
    a_if.addr          = ad;
    a_if.wdata         = wd;
    a_if.reg_target_in = rt;
  endtask

  task automatic a_idle();
    a_if.req_valid = 1'b0;
    a_if.mem_rd    = 1'b0;
    a_if.mem_wr    = 1'b0;
  endtask

  task automatic b_drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd);
    b_if.req_valid     = 1'b1;
    b_if.mem_rd        = rd;
    b_if.mem_wr        = wr;
    b_if.size          = sz;
    b_if.load_unsigned = uns;
    b_if.addr          = ad;
    b_if.wdata         = wd;
    b_if.reg_target_in = 5'd9;
  endtask

  task automatic a_store(input logic [31:0] ad, input logic [31:0] wd, input logic [1:0] sz,
                         input logic rd_too, input string tag);
    a_drive(rd_too, 1'b1, sz, 1'b0, ad, wd, 5'd3);
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, a_if.stall}, 32'd0);
    chk({tag, "_vld"},   {31'd0, a_if.rdata_valid}, 32'd0);
    chk({tag, "_mis"},   {31'd0, a_if.misalign_exc}, 32'd0);
    @(posedge clk); #1;
    a_idle();
  endtask

  task automatic a_load(input logic [31:0] ad, input logic [1:0] sz, input logic uns,
                        input logic [31:0] exp, input string tag);
    a_drive(1'b1, 1'b0, sz, uns, ad, 32'h0, 5'd17);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({tag, "_alu"}, a_if.alu_ans_out, ad);
        chk({tag, "_rt"},  {27'd0, a_if.reg_target_out}, 32'd17);
      end
      chk({tag, "_stall"}, {31'd0, a_if.stall}, 32'd1);
      chk({tag, "_vldlo"}, {31'd0, a_if.rdata_valid}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_stall_done"}, {31'd0, a_if.stall}, 32'd0);
    chk({tag, "_vld"},        {31'd0, a_if.rdata_valid}, 32'd1);
    chk({tag, "_rdata"},      a_if.rdata, exp);
    @(posedge clk); #1;
    a_idle();
  endtask

  initial begin
    a_idle();
    a_if.size = 2'b00; a_if.load_unsigned = 1'b0; a_if.addr = 32'h0;
    a_if.wdata = 32'h0; a_if.reg_target_in = 5'd0;
    b_if.req_valid = 1'b0; b_if.mem_rd = 1'b0; b_if.mem_wr = 1'b0;
    b_if.size = 2'b00; b_if.load_unsigned = 1'b0; b_if.addr = 32'h0;
    b_if.wdata = 32'h0; b_if.reg_target_in = 5'd0;

    // Reset state, including a load request held while in reset.
    @(negedge clk);
    chk("rst_stall",  {31'd0, a_if.stall}, 32'd0);
    chk("rst_vld",    {31'd0, a_if.rdata_valid}, 32'd0);
    chk("rst_mis",    {31'd0, a_if.misalign_exc}, 32'd0);
    chk("rst_rdata",  a_if.rdata, 32'd0);
    a_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd1);
    #1;
    chk("rst_req_stall", {31'd0, a_if.stall}, 32'd0);
    a_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word store followed by byte loads with sign and zero extension.
    a_store(32'h010, 32'h8000_00FF, 2'b10, 1'b0, "sw10");
    a_load(32'h010, 2'b00, 1'b0, 32'hFFFF_FFFF, "lb10");
    a_load(32'h010, 2'b00, 1'b1, 32'h0000_00FF, "lbu10");
    a_load(32'h013, 2'b00, 1'b0, 32'hFFFF_FF80, "lb13");
    a_load(32'h013, 2'b00, 1'b1, 32'h0000_0080, "lbu13");

    // Halfword store into the upper lane.
    a_store(32'h020, 32'h1122_3344, 2'b10, 1'b0, "sw20");
    a_store(32'h022, 32'h7777_BEEF, 2'b01, 1'b0, "sh22");
    a_load(32'h020, 2'b10, 1'b0, 32'hBEEF_3344, "lw20");
    a_load(32'h022, 2'b01, 1'b0, 32'hFFFF_BEEF, "lh22");
    a_load(32'h022, 2'b01, 1'b1, 32'h0000_BEEF, "lhu22");
    a_load(32'h020, 2'b01, 1'b0, 32'h0000_3344, "lh20");

    // Byte store into lane 1.
    a_store(32'h040, 32'h0000_0000, 2'b10, 1'b0, "sw40");
    a_store(32'h041, 32'h1234_56AB, 2'b00, 1'b0, "sb41");
    a_load(32'h040, 2'b10, 1'b0, 32'h0000_AB00, "lw40");
    a_load(32'h041, 2'b00, 1'b0, 32'hFFFF_FFAB, "lb41");

    // Address wrap modulo 4*DEPTH_WORDS.
    a_store(32'h1000, 32'hCAFE_F00D, 2'b10, 1'b0, "sw1000");
    a_load(32'h000, 2'b10, 1'b0, 32'hCAFE_F00D, "lw0wrap");

    // With mem_rd and mem_wr both high, the request is a store.
    a_store(32'h030, 32'h5A5A_1234, 2'b10, 1'b1, "rdwr30");
    a_load(32'h030, 2'b10, 1'b0, 32'h5A5A_1234, "lw30");

    // Misaligned word store to 0x013.
`ifdef MEMU_ALIGN_TRAP_EN
    a_drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h013, 32'hDEAD_BEEF, 5'd3);
    @(negedge clk);
    chk("mis_exc",   {31'd0, a_if.misalign_exc}, 32'd1);
    chk("mis_stall", {31'd0, a_if.stall}, 32'd0);
    @(posedge clk); #1;
    a_idle();
    @(negedge clk);
    chk("mis_exc_off", {31'd0, a_if.misalign_exc}, 32'd0);
    @(posedge clk); #1;
    a_load(32'h010, 2'b10, 1'b0, 32'h8000_00FF, "mis_unch");
`else
    a_store(32'h013, 32'hDEAD_BEEF, 2'b10, 1'b0, "sw13trunc");
    a_load(32'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, "lw10trunc");
`endif

    // Reset asserted during the WAIT cycle of a load.
    a_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 5'd4);
    @(posedge clk); #1;
    chk("mid_wait_stall", {31'd0, a_if.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, a_if.stall}, 32'd0);
    chk("mid_rst_vld",   {31'd0, a_if.rdata_valid}, 32'd0);
    a_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_novld", {31'd0, a_if.rdata_valid}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", {31'd0, a_if.rdata_valid}, 32'd0);
    @(posedge clk); #1;
    a_load(32'h020, 2'b10, 1'b0, 32'hBEEF_3344, "post_rst_lw");

    // RD_LAT=0 instance: combinational read in the request cycle.
    b_drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678);
    @(negedge clk);
    chk("b_sw_stall", {31'd0, b_if.stall}, 32'd0);
    @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("b_lw_rdata", b_if.rdata, 32'h1234_5678);
    chk("b_lw_vld",   {31'd0, b_if.rdata_valid}, 32'd1);
    chk("b_lw_stall", {31'd0, b_if.stall}, 32'd0);
    @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    @(negedge clk);
    chk("b_lb103", b_if.rdata, 32'h0000_0012);
    @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    @(negedge clk);
    chk("b_lhu102", b_if.rdata, 32'h0000_1234);
    @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    @(negedge clk);
    chk("b_lbu100", b_if.rdata, 32'h0000_0078);
    chk("b_lbu_stall", {31'd0, b_if.stall}, 32'd0);
    @(posedge clk); #1;
    b_if.req_valid = 1'b0; b_if.mem_rd = 1'b0;
    @(negedge clk);
    chk("b_idle_vld", {31'd0, b_if.rdata_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
